// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU command front end: op selects, response flag
// bit positions and the issuer FSM encoding.
package fpu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam int unsigned FLG_OVF = 0;
    localparam int unsigned FLG_UNF = 1;
    localparam int unsigned FLG_INV = 2;
    localparam int unsigned FLG_DZ  = 3;
    localparam int unsigned FLAG_W  = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StIssue = 2'b01,
        StResp  = 2'b10
    } issuer_state_e;

    function automatic logic is_div_zero(logic [1:0] sel, logic b_is_zero);
        return (sel == OP_DIV) && b_is_zero;
    endfunction

endpackage

// File: rtl/fpu_cmd_fifo.sv
// Synchronous command FIFO with wrapping pointers and an occupancy count.
// Pushes when full and pops when empty are ignored.
module fpu_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 18
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Storage is reset too so the head never presents X to the issuer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fpu_cmd_issuer.sv
// Buffers FPU commands, presents them one at a time on registered fpu_* lines
// and returns the registered result under a valid/ready response handshake.
module fpu_cmd_issuer
    import fpu_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RES_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [DATA_W-1:0]        cmd_a,
    input  logic [DATA_W-1:0]        cmd_b,
    input  logic [1:0]               cmd_sel,
    output logic [DATA_W-1:0]        fpu_a,
    output logic [DATA_W-1:0]        fpu_b,
    output logic [1:0]               fpu_sel,
    input  logic [RES_W-1:0]         fpu_y,
    input  logic                     fpu_overflow,
    input  logic                     fpu_underflow,
    input  logic                     fpu_invalid,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [RES_W-1:0]         rsp_y,
    output logic [FLAG_W-1:0]        rsp_flags,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned EW = 2 * DATA_W + 2;

    issuer_state_e      state_q;
    logic [DATA_W-1:0]  fpu_a_q;
    logic [DATA_W-1:0]  fpu_b_q;
    logic [1:0]         fpu_sel_q;
    logic               rsp_valid_q;
    logic [RES_W-1:0]   rsp_y_q;
    logic [FLAG_W-1:0]  rsp_flags_q;

    logic [EW-1:0]      head;
    logic [DATA_W-1:0]  head_a;
    logic [DATA_W-1:0]  head_b;
    logic [1:0]         head_sel;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;
    logic               div_zero;

    fpu_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid),
        .pop   (fifo_pop),
        .wdata ({cmd_sel, cmd_b, cmd_a}),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    assign head_a   = head[DATA_W-1:0];
    assign head_b   = head[2*DATA_W-1:DATA_W];
    assign head_sel = head[EW-1 -: 2];

    // The issued entry leaves the FIFO while its result is being captured.
    assign fifo_pop = (state_q == StIssue);
    assign div_zero = is_div_zero(fpu_sel_q, (fpu_b_q == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            fpu_a_q     <= '0;
            fpu_b_q     <= '0;
            fpu_sel_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_y_q     <= '0;
            rsp_flags_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!fifo_empty) begin
                        fpu_a_q   <= head_a;
                        fpu_b_q   <= head_b;
                        fpu_sel_q <= head_sel;
                        state_q   <= StIssue;
                    end
                end
                StIssue: begin
                    rsp_valid_q <= 1'b1;
                    rsp_flags_q <= '0;
                    if (div_zero) begin
                        rsp_y_q             <= '1;
                        rsp_flags_q[FLG_DZ] <= 1'b1;
                    end else begin
                        rsp_y_q              <= fpu_y;
                        rsp_flags_q[FLG_OVF] <= fpu_overflow;
                        rsp_flags_q[FLG_UNF] <= fpu_underflow;
                        rsp_flags_q[FLG_INV] <= fpu_invalid;
                    end
                    state_q <= StResp;
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        if (!fifo_empty) begin
                            fpu_a_q   <= head_a;
                            fpu_b_q   <= head_b;
                            fpu_sel_q <= head_sel;
                            state_q   <= StIssue;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cmd_ready = !fifo_full;
    assign fpu_a     = fpu_a_q;
    assign fpu_b     = fpu_b_q;
    assign fpu_sel   = fpu_sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_flags = rsp_flags_q;

endmodule

// File: tb/tb_fpu_cmd_issuer.sv
// Bench for fpu_cmd_issuer: directed scenarios plus random traffic, checked
// against an in-order command queue and a behavioural FPU stand-in.
module tb_fpu_cmd_issuer;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned RES_W  = 16;
    localparam int unsigned CW     = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] sel;
    } cmd_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;
    logic [1:0]        cmd_sel;
    logic [DATA_W-1:0] fpu_a;
    logic [DATA_W-1:0] fpu_b;
    logic [1:0]        fpu_sel;
    logic [RES_W-1:0]  fpu_y;
    logic              fpu_overflow;
    logic              fpu_underflow;
    logic              fpu_invalid;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [RES_W-1:0]  rsp_y;
    logic [3:0]        rsp_flags;
    logic [CW-1:0]     count;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   accepted;
    cmd_t exp_q[$];

    fpu_cmd_issuer #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .RES_W  (RES_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_a         (cmd_a),
        .cmd_b         (cmd_b),
        .cmd_sel       (cmd_sel),
        .fpu_a         (fpu_a),
        .fpu_b         (fpu_b),
        .fpu_sel       (fpu_sel),
        .fpu_y         (fpu_y),
        .fpu_overflow  (fpu_overflow),
        .fpu_underflow (fpu_underflow),
        .fpu_invalid   (fpu_invalid),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_y         (rsp_y),
        .rsp_flags     (rsp_flags),
        .count         (count)
    );

    always #5 clk = ~clk;

    // Stand-in FPU: {invalid, underflow, overflow, y}. Divide by zero returns
    // junk with invalid set so the issuer's override is observable.
    function automatic logic [18:0] fpu_ref(logic [7:0] a, logic [7:0] b, logic [1:0] sel);
        logic [15:0] y;
        logic        ovf;
        logic        unf;
        logic        inv;
        case (sel)
            2'b00:   y = 16'(a) + 16'(b);
            2'b01:   y = 16'(a) - 16'(b);
            2'b10:   y = 16'(a) * 16'(b);
            default: y = (b == 8'h00) ? 16'h1234 : 16'(a / b);
        endcase
        ovf = (sel != 2'b11) && (y > 16'h00FF);
        unf = (a == 8'h00);
        inv = (sel == 2'b11) && ((b == 8'h00) || (a < b));
        return {inv, unf, ovf, y};
    endfunction

    // Expected response {flags, y} for one command.
    function automatic logic [19:0] exp_rsp(cmd_t c);
        logic [18:0] r;
        if (c.sel == 2'b11 && c.b == 8'h00) return {4'b1000, 16'hFFFF};
        r = fpu_ref(c.a, c.b, c.sel);
        return {1'b0, r[18:16], r[15:0]};
    endfunction

    always_comb begin
        logic [18:0] r;
        r             = fpu_ref(fpu_a, fpu_b, fpu_sel);
        fpu_y         = r[15:0];
        fpu_overflow  = r[16];
        fpu_underflow = r[17];
        fpu_invalid   = r[18];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One cycle: account for the handshakes that the coming edge will perform,
    // then advance to the next falling edge.
    task automatic step();
        bit          do_push;
        bit          do_rsp;
        cmd_t        c;
        logic [19:0] e;
        do_push = cmd_valid && cmd_ready;
        do_rsp  = rsp_valid && rsp_ready;
        if (do_rsp) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_valid), 32'(0));
            end else begin
                c = exp_q.pop_front();
                e = exp_rsp(c);
                check("rsp_y", 32'(rsp_y), 32'(e[15:0]));
                check("rsp_flags", 32'(rsp_flags), 32'(e[19:16]));
                check("fpu_ops", {14'h0, fpu_sel, fpu_b, fpu_a}, {14'h0, c.sel, c.b, c.a});
            end
        end
        if (do_push) begin
            exp_q.push_back('{a: cmd_a, b: cmd_b, sel: cmd_sel});
            accepted++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] sel);
        cmd_a     = a;
        cmd_b     = b;
        cmd_sel   = sel;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        cmd_valid = 1'b0;
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) step();
        if (exp_q.size() > 0) check("drain_timeout", 32'(exp_q.size()), 32'(0));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'(1));
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(0));
        check({tag, "_count"}, 32'(count), 32'(0));
        check({tag, "_fpu"}, {14'h0, fpu_sel, fpu_b, fpu_a}, 32'(0));
    endtask

    task automatic latency_add(input string tag);
        rsp_ready = 1'b1;
        send(8'h10, 8'h20, 2'b00);
        check({tag, "_lat_k"}, 32'(rsp_valid), 32'(0));
        step();
        check({tag, "_lat_k1"}, 32'(rsp_valid), 32'(0));
        step();
        check({tag, "_lat_k2"}, 32'(rsp_valid), 32'(1));
        step();
        check({tag, "_hold_1"}, 32'(rsp_valid), 32'(0));
        check({tag, "_done"}, 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_sel   = '0;
        rsp_ready = 1'b0;
        accepted  = 0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        check("reset_rsp_y", {12'h0, rsp_flags, rsp_y}, 32'(0));
        rst = 1'b0;
        @(negedge clk);

        latency_add("add");

        // Overflowing multiply followed by an underflowing add, in order.
        send(8'hFF, 8'hFF, 2'b10);
        send(8'h00, 8'h03, 2'b00);
        drain();

        send(8'h09, 8'h00, 2'b11);
        drain();

        // Back-pressure: six back-to-back offers, one held in RESP plus DEPTH.
        rsp_ready = 1'b0;
        accepted  = 0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cmd_a   = 8'(8'h11 * (i + 1));
            cmd_b   = 8'(i + 1);
            cmd_sel = 2'(i);
            step();
        end
        cmd_valid = 1'b0;
        check("bp_accepted", 32'(accepted), 32'(5));
        check("bp_count", 32'(count), 32'(4));
        check("bp_cmd_ready", 32'(cmd_ready), 32'(0));
        check("bp_rsp_valid", 32'(rsp_valid), 32'(1));
        drain();
        check("bp_drain_count", 32'(count), 32'(0));
        check("bp_drain_ready", 32'(cmd_ready), 32'(1));

        // Push coinciding with the pop of the entry being issued.
        rsp_ready = 1'b0;
        send(8'h21, 8'h02, 2'b00);
        send(8'h22, 8'h03, 2'b01);
        send(8'h23, 8'h04, 2'b10);
        check("pp_pre_count", 32'(count), 32'(2));
        check("pp_pre_valid", 32'(rsp_valid), 32'(1));
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        send(8'h24, 8'h05, 2'b11);
        check("pp_count", 32'(count), 32'(2));
        check("pp_fpu_a", 32'(fpu_a), 32'(8'h22));
        drain();

        // Asynchronous reset while a response is held with three queued.
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(8'(8'h40 + i), 8'h01, 2'b00);
        check("rr_pre_valid", 32'(rsp_valid), 32'(1));
        check("rr_pre_count", 32'(count), 32'(3));
        #1 rst = 1'b1;
        #1;
        check_idle_outputs("rr_async");
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        latency_add("rr_after");

        // Random traffic with random back-pressure.
        for (int i = 0; i < 400; i++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_a     = 8'($urandom);
            cmd_b     = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            cmd_sel   = 2'($urandom);
            rsp_ready = 1'($urandom_range(0, 1));
            step();
        end
        drain();
        check("rand_end_count", 32'(count), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
